// File: rtl/uart_core_param.sv
// Parametrised UART transceiver: fractional NCO 16x tick, TX/RX FSMs, sticky errors, RX buffer.
// Define UART_RX_FIFO_EN for an RX_DEPTH-entry FIFO; otherwise RX uses a single holding register.
module uart_core_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BAUD_ACC_W = 16,
    parameter int RX_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BAUD_ACC_W-1:0] baud_inc,
    input  logic [DATA_BITS-1:0]  tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  TXD,
    input  logic                  RXD,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic                  err_clr,
    output logic                  framing_error,
    output logic                  parity_error,
    output logic                  overrun_error
);
    localparam logic       HAS_PARITY = (PARITY != 0);
    localparam logic       ODD_PARITY = (PARITY == 2);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ ODD_PARITY;
    endfunction

    logic [BAUD_ACC_W-1:0] acc_r;
    logic [BAUD_ACC_W:0]   acc_sum_s;
    logic                  tick_r;

    assign acc_sum_s = {1'b0, acc_r} + {1'b0, baud_inc};

    // NCO accumulator; its carry out is the 16x oversample tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            acc_r  <= acc_sum_s[BAUD_ACC_W-1:0];
            tick_r <= acc_sum_s[BAUD_ACC_W];
        end
    end

    // ---------------- transmitter ----------------
    state_t               tx_state_r, tx_state_nxt_s;
    logic [3:0]           tx_tick_r, tx_tick_nxt_s;
    logic [3:0]           tx_bit_r, tx_bit_nxt_s;
    logic [DATA_BITS-1:0] tx_buf_r, tx_buf_nxt_s;
    logic                 tx_par_r, tx_par_nxt_s;
    logic                 txd_r, txd_nxt_s;
    logic                 tx_ready_r;
    logic                 tx_bit_end_s;

    assign tx_bit_end_s = tick_r && (tx_tick_r == 4'd15);

    // TX next state; the data buffer shifts right so bit 0 is always the bit on the line
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_bit_nxt_s   = tx_bit_r;
        tx_buf_nxt_s   = tx_buf_r;
        tx_par_nxt_s   = tx_par_r;
        if (tick_r) begin
            tx_tick_nxt_s = tx_tick_r + 4'd1;
        end else begin
            tx_tick_nxt_s = tx_tick_r;
        end
        case (tx_state_r)
            ST_IDLE: begin
                tx_tick_nxt_s = 4'd0;
                tx_bit_nxt_s  = 4'd0;
                if (tx_valid && tx_ready_r) begin
                    tx_state_nxt_s = ST_START;
                    tx_buf_nxt_s   = tx_data;
                    tx_par_nxt_s   = calc_parity(tx_data);
                end else begin
                    tx_state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_bit_end_s) begin
                    tx_state_nxt_s = ST_DATA;
                end else begin
                    tx_state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tx_bit_end_s) begin
                    tx_buf_nxt_s = tx_buf_r >> 1;
                    if (tx_bit_r == LAST_DATA) begin
                        tx_bit_nxt_s   = 4'd0;
                        tx_state_nxt_s = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_bit_nxt_s = tx_bit_r + 4'd1;
                    end
                end else begin
                    tx_state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tx_bit_end_s) begin
                    tx_state_nxt_s = ST_STOP;
                end else begin
                    tx_state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tx_bit_end_s) begin
                    if (tx_bit_r == LAST_STOP) begin
                        tx_bit_nxt_s   = 4'd0;
                        tx_state_nxt_s = ST_IDLE;
                    end else begin
                        tx_bit_nxt_s = tx_bit_r + 4'd1;
                    end
                end else begin
                    tx_state_nxt_s = ST_STOP;
                end
            end
            default: tx_state_nxt_s = ST_IDLE;
        endcase
        case (tx_state_nxt_s)
            ST_START:  txd_nxt_s = 1'b0;
            ST_DATA:   txd_nxt_s = tx_buf_nxt_s[0];
            ST_PARITY: txd_nxt_s = tx_par_nxt_s;
            default:   txd_nxt_s = 1'b1;
        endcase
    end

    // TX state and registered line/ready outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= ST_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 4'd0;
            tx_buf_r   <= '0;
            tx_par_r   <= 1'b0;
            txd_r      <= 1'b1;
            tx_ready_r <= 1'b1;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_tick_r  <= tx_tick_nxt_s;
            tx_bit_r   <= tx_bit_nxt_s;
            tx_buf_r   <= tx_buf_nxt_s;
            tx_par_r   <= tx_par_nxt_s;
            txd_r      <= txd_nxt_s;
            tx_ready_r <= (tx_state_nxt_s == ST_IDLE);
        end
    end

    // ---------------- receiver ----------------
    logic                 rxd_meta_r, rxd_sync_r, rxd_prev_r;
    state_t               rx_state_r, rx_state_nxt_s;
    logic [3:0]           rx_tick_r, rx_tick_nxt_s;
    logic [3:0]           rx_bit_r, rx_bit_nxt_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_nxt_s;
    logic                 rx_par_r, rx_par_nxt_s;
    logic                 rx_sample_s, frame_done_s;

    assign rx_sample_s = tick_r && (rx_tick_r == 4'd15);

    // RX next state; START re-centres the tick counter on mid-bit after the glitch check
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_bit_nxt_s   = rx_bit_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_par_nxt_s   = rx_par_r;
        frame_done_s   = 1'b0;
        if (tick_r) begin
            rx_tick_nxt_s = rx_tick_r + 4'd1;
        end else begin
            rx_tick_nxt_s = rx_tick_r;
        end
        case (rx_state_r)
            ST_IDLE: begin
                rx_tick_nxt_s = 4'd0;
                rx_bit_nxt_s  = 4'd0;
                if (rxd_prev_r && !rxd_sync_r) begin
                    rx_state_nxt_s = ST_START;
                end else begin
                    rx_state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_r && (rx_tick_r == 4'd7)) begin
                    rx_tick_nxt_s  = 4'd0;
                    rx_state_nxt_s = rxd_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    rx_state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (rx_sample_s) begin
                    rx_shift_nxt_s = {rxd_sync_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bit_r == LAST_DATA) begin
                        rx_bit_nxt_s   = 4'd0;
                        rx_state_nxt_s = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_nxt_s = rx_bit_r + 4'd1;
                    end
                end else begin
                    rx_state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (rx_sample_s) begin
                    rx_par_nxt_s   = rxd_sync_r;
                    rx_state_nxt_s = ST_STOP;
                end else begin
                    rx_state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (rx_sample_s) begin
                    frame_done_s   = 1'b1;
                    rx_state_nxt_s = ST_IDLE;
                end else begin
                    rx_state_nxt_s = ST_STOP;
                end
            end
            default: rx_state_nxt_s = ST_IDLE;
        endcase
    end

    // RXD synchroniser, edge history and RX state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
            rx_state_r <= ST_IDLE;
            rx_tick_r  <= 4'd0;
            rx_bit_r   <= 4'd0;
            rx_shift_r <= '0;
            rx_par_r   <= 1'b0;
        end else begin
            rxd_meta_r <= RXD;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
            rx_state_r <= rx_state_nxt_s;
            rx_tick_r  <= rx_tick_nxt_s;
            rx_bit_r   <= rx_bit_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
            rx_par_r   <= rx_par_nxt_s;
        end
    end

    // ---------------- RX buffer and error flags ----------------
    logic                 rx_valid_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 full_s, pop_s, push_req_s, push_s;
    logic                 framing_set_s, parity_set_s, overrun_set_s;
    logic                 framing_r, parity_r, overrun_r;

    assign pop_s         = rx_valid_r && rx_ready;
    assign push_req_s    = frame_done_s && rxd_sync_r;
    assign push_s        = push_req_s && (!full_s || pop_s);
    assign framing_set_s = frame_done_s && !rxd_sync_r;
    assign parity_set_s  = push_req_s && HAS_PARITY && (rx_par_r != calc_parity(rx_shift_r));
    assign overrun_set_s = push_req_s && full_s && !pop_s;

`ifdef UART_RX_FIFO_EN
    localparam int               PTR_W   = $clog2(RX_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(RX_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_BITS-1:0] mem_r [RX_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [PTR_W:0]       count_r, count_nxt_s, count_after_pop_s;
    logic [DATA_BITS-1:0] head_s;

    assign full_s = (count_r == DEPTH_C);

    // Next occupancy and the value that becomes the registered head of queue
    always_comb begin
        if (pop_s) begin
            rd_ptr_nxt_s      = rd_ptr_r + PTR_ONE;
            count_after_pop_s = count_r - CNT_ONE;
        end else begin
            rd_ptr_nxt_s      = rd_ptr_r;
            count_after_pop_s = count_r;
        end
        if (push_s) begin
            count_nxt_s = count_after_pop_s + CNT_ONE;
        end else begin
            count_nxt_s = count_after_pop_s;
        end
        if (push_s && (count_after_pop_s == '0)) begin
            head_s = rx_shift_r;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= rx_shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            rx_valid_r <= (count_nxt_s != '0);
            rx_data_r  <= (count_nxt_s != '0) ? head_s : rx_data_r;
        end
    end
`else
    assign full_s = rx_valid_r;

    // Single holding register; a pop frees it in the same cycle a new frame lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_r <= 1'b0;
            rx_data_r  <= '0;
        end else if (push_s) begin
            rx_valid_r <= 1'b1;
            rx_data_r  <= rx_shift_r;
        end else if (pop_s) begin
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end
`endif

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framing_r <= 1'b0;
            parity_r  <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            framing_r <= framing_set_s | (framing_r & ~err_clr);
            parity_r  <= parity_set_s  | (parity_r  & ~err_clr);
            overrun_r <= overrun_set_s | (overrun_r & ~err_clr);
        end
    end

    assign tx_ready      = tx_ready_r;
    assign TXD           = txd_r;
    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign framing_error = framing_r;
    assign parity_error  = parity_r;
    assign overrun_error = overrun_r;
endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param (8 data bits, even parity, 1 stop, bit = 256 clk).
`timescale 1ns/1ps
module tb_uart_core_param;
    localparam int BIT_CLK = 256;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_inc;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, txd, rxd, rxd_drv, loop_en;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, err_clr;
    logic        framing_error, parity_error, overrun_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rx_valid && rx_ready) got_q.push_back(rx_data);
    assign rxd = loop_en ? txd : rxd_drv;

    uart_core_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .BAUD_ACC_W(16), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .baud_inc(baud_inc), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .TXD(txd), .RXD(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .err_clr(err_clr), .framing_error(framing_error),
        .parity_error(parity_error), .overrun_error(overrun_error));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line order of a frame: bit 0 is sent first (start, data LSB first, even parity, stop)
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic pop_one();
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] b;
        b = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd_drv = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic tx_send(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (!tx_ready) begin
            errors++; $display("FAIL tx_send_timeout: tx_ready=%b required 1", tx_ready);
        end
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
    endtask

    task automatic wait_rx_valid();
        int n;
        n = 0;
        while (!rx_valid && n < 4000) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; baud_inc = 16'd4096; tx_data = 8'h00; tx_valid = 1'b0;
        rxd_drv = 1'b1; loop_en = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (txd !== 1'b1)           begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
        if (tx_ready !== 1'b1)      begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        if (rx_valid !== 1'b0)      begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        if (rx_data !== 8'h00)      begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing: got %b want 0", framing_error); end
        if (parity_error !== 1'b0)  begin errors++; $display("FAIL reset_parity: got %b want 0", parity_error); end
        if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_error); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tx_frame(input logic [7:0] d);
        logic [10:0] b;
        int c0, n;
        b = frame_bits(d);
        tx_send(d);
        c0 = cyc;
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_drop: got %b want 0", tx_ready); end
        for (int i = 0; i < 11; i++) begin
            repeat ((i == 0) ? 128 : BIT_CLK) @(negedge clk);
            checks++;
            if (txd !== b[i]) begin
                errors++; $display("FAIL tx_bit%0d data=%h: got %b want %b", i, d, txd, b[i]);
            end
        end
        n = 0;
        while (!tx_ready && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (!tx_ready || (cyc - c0) < 2801 || (cyc - c0) > 2816) begin
            errors++; $display("FAIL tx_busy_len: got %0d clk want 2801..2816", cyc - c0);
        end
    endtask

    task automatic test_loopback(input logic [7:0] d);
        loop_en = 1'b1;
        tx_send(d);
        wait_rx_valid();
        checks += 3;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL loop_valid: got %b want 1", rx_valid); end
        if (rx_data !== d)     begin errors++; $display("FAIL loop_data: got %h want %h", rx_data, d); end
        if ({framing_error, parity_error, overrun_error} !== 3'b000) begin
            errors++; $display("FAIL loop_flags: got %b want 000", {framing_error, parity_error, overrun_error});
        end
        pop_one();
        while (!tx_ready) @(negedge clk);
        loop_en = 1'b0;
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0, 1'b0);
        checks += 2;
        if (framing_error !== 1'b1) begin errors++; $display("FAIL framing_set: got %b want 1", framing_error); end
        if (rx_valid !== 1'b0)      begin errors++; $display("FAIL framing_drop: got %b want 0", rx_valid); end
        clear_errors();
        checks++;
        if (framing_error !== 1'b0) begin errors++; $display("FAIL framing_clr: got %b want 0", framing_error); end
    endtask

    task automatic test_parity();
        send_frame(8'h0F, 1'b1, 1'b1);
        checks += 3;
        if (parity_error !== 1'b1) begin errors++; $display("FAIL parity_set: got %b want 1", parity_error); end
        if (rx_valid !== 1'b1)     begin errors++; $display("FAIL parity_valid: got %b want 1", rx_valid); end
        if (rx_data !== 8'h0F)     begin errors++; $display("FAIL parity_data: got %h want 0f", rx_data); end
        pop_one();
        clear_errors();
    endtask

    task automatic test_rx_random(input int n);
        logic [7:0] d;
        logic flip, stop;
        for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            flip = ($urandom_range(0, 2) == 0);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, (^d) ^ flip, stop);
            checks += 3;
            if (framing_error !== !stop) begin
                errors++; $display("FAIL rnd_framing d=%h: got %b want %b", d, framing_error, !stop);
            end
            if (parity_error !== (stop & flip)) begin
                errors++; $display("FAIL rnd_parity d=%h: got %b want %b", d, parity_error, stop & flip);
            end
            if (rx_valid !== stop) begin
                errors++; $display("FAIL rnd_valid d=%h: got %b want %b", d, rx_valid, stop);
            end
            if (stop) begin
                checks++;
                if (rx_data !== d) begin errors++; $display("FAIL rnd_data: got %h want %h", rx_data, d); end
                pop_one();
            end
            clear_errors();
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic exp_ovr;
        got_q.delete(); exp_q.delete();
        exp_ovr = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            d = 8'(i + 1);
            send_frame(d, ^d, 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovr = 1'b1;
        end
        checks++;
        if (overrun_error !== exp_ovr) begin errors++; $display("FAIL overrun_set: got %b want %b", overrun_error, exp_ovr); end
        for (int i = 0; i < DEPTH; i++) pop_one();
        checks += 2;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_empty: got %b want 0", rx_valid); end
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL overrun_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL overrun_order%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        clear_errors();
    endtask

    task automatic test_glitch();
        rxd_drv = 1'b0;
        repeat (64) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (600) @(negedge clk);
        checks += 2;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
        if ({framing_error, parity_error, overrun_error} !== 3'b000) begin
            errors++; $display("FAIL glitch_flags: got %b want 000", {framing_error, parity_error, overrun_error});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1;
        int n;
        d0 = 8'($urandom); d1 = 8'($urandom);
        got_q.delete();
        loop_en = 1'b1; rx_ready = 1'b1;
        tx_send(d0);
        tx_send(d1);
        n = 0;
        while (got_q.size() < 2 && n < 6000) begin @(negedge clk); n++; end
        checks += 2;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", got_q.size());
        end else if (got_q[0] !== d0 || got_q[1] !== d1) begin
            errors++; $display("FAIL b2b_data: got %h %h want %h %h", got_q[0], got_q[1], d0, d1);
        end
        if ({framing_error, parity_error, overrun_error} !== 3'b000) begin
            errors++; $display("FAIL b2b_flags: got %b want 000", {framing_error, parity_error, overrun_error});
        end
        rx_ready = 1'b0;
        while (!tx_ready) @(negedge clk);
        loop_en = 1'b0;
    endtask

    task automatic test_baud_freeze();
        logic held;
        int changes, n;
        tx_send(8'($urandom));
        repeat (600) @(negedge clk);
        baud_inc = 16'd0;
        repeat (40) @(negedge clk);
        held = txd;
        changes = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (txd !== held) changes++;
        end
        checks += 2;
        if (changes != 0)      begin errors++; $display("FAIL freeze_txd: got %0d changes want 0", changes); end
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL freeze_ready: got %b want 0", tx_ready); end
        baud_inc = 16'd4096;
        n = 0;
        while (!tx_ready && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL freeze_resume: got %b want 1", tx_ready); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom);
        send_frame(d, ^d, 1'b1);
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", rx_valid); end
        tx_send(8'h00);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (txd !== 1'b1)      begin errors++; $display("FAIL rstmid_txd: got %b want 1", txd); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fifo: got %b want 0", rx_valid); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tx_frame(8'hA5);
        test_tx_frame(8'($urandom));
        test_tx_frame(8'($urandom));
        test_loopback(8'h3C);
        test_loopback(8'($urandom));
        test_framing();
        test_parity();
        test_rx_random(4);
        test_overrun();
        test_glitch();
        test_back_to_back();
        test_baud_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
